// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Instruction decoder. It takes the opcode (instruction[31:27]) and the
//   immediate bit (instruction[26]) and decodes them into a one-hot style
//   control vector. The control vector is registered, so the output is valid
//   one clock after the instruction is sampled. Bits 25:0 of the instruction
//   play no part in the decode.
//
// Ports
//   clk              in   1   system clock, rising edge
//   rst_n            in   1   asynchronous active-low reset; clears the output
//   instruction      in  32   instruction word to decode
//   control_signals  out 22   registered decoded control vector:
//                               0 isSt   1 isLd   2 isBeq  3 isBgt  4 isRet
//                               5 isImm  6 isWb   7 isUbr  8 isCall 9 isAdd
//                              10 isSub 11 isCmp 12 isMul 13 isDiv 14 isMod
//                              15 isLsl 16 isLsr 17 isAsr 18 isOr  19 isAnd
//                              20 isNot 21 isMov
// -----------------------------------------------------------------------------
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [21:0] control_signals
);

  // opcode values
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  // control vector bit positions
  localparam int B_ST   = 0;
  localparam int B_LD   = 1;
  localparam int B_BEQ  = 2;
  localparam int B_BGT  = 3;
  localparam int B_RET  = 4;
  localparam int B_IMM  = 5;
  localparam int B_WB   = 6;
  localparam int B_UBR  = 7;
  localparam int B_CALL = 8;
  localparam int B_ADD  = 9;
  localparam int B_SUB  = 10;
  localparam int B_CMP  = 11;
  localparam int B_MUL  = 12;
  localparam int B_DIV  = 13;
  localparam int B_MOD  = 14;
  localparam int B_LSL  = 15;
  localparam int B_LSR  = 16;
  localparam int B_ASR  = 17;
  localparam int B_OR   = 18;
  localparam int B_AND  = 19;
  localparam int B_NOT  = 20;
  localparam int B_MOV  = 21;

  logic [4:0]  opcode;
  logic        imm_bit;
  logic        opcode_valid;
  logic [21:0] decoded;
  logic        unused_low_bits;

  assign opcode          = instruction[31:27];
  assign imm_bit         = instruction[26];
  assign unused_low_bits = ^instruction[25:0];

  // Opcodes 21-31 are undefined and must decode to all zeros, including
  // the immediate flag.
  assign opcode_valid = (opcode <= OP_RET);

  always_comb begin
    decoded        = '0;
    decoded[B_IMM] = opcode_valid & imm_bit;
    case (opcode)
      OP_ADD: begin
        decoded[B_ADD] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_SUB: begin
        decoded[B_SUB] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_MUL: begin
        decoded[B_MUL] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_DIV: begin
        decoded[B_DIV] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_MOD: begin
        decoded[B_MOD] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_CMP: begin
        decoded[B_CMP] = 1'b1;
      end
      OP_AND: begin
        decoded[B_AND] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_OR: begin
        decoded[B_OR] = 1'b1;
        decoded[B_WB] = 1'b1;
      end
      OP_NOT: begin
        decoded[B_NOT] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_MOV: begin
        decoded[B_MOV] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_LSL: begin
        decoded[B_LSL] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_LSR: begin
        decoded[B_LSR] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_ASR: begin
        decoded[B_ASR] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_NOP: begin
        // only the immediate flag may be set, handled above
      end
      // load and store use the adder to form the effective address
      OP_LD: begin
        decoded[B_LD]  = 1'b1;
        decoded[B_ADD] = 1'b1;
        decoded[B_WB]  = 1'b1;
      end
      OP_ST: begin
        decoded[B_ST]  = 1'b1;
        decoded[B_ADD] = 1'b1;
      end
      OP_BEQ: begin
        decoded[B_BEQ] = 1'b1;
      end
      OP_BGT: begin
        decoded[B_BGT] = 1'b1;
      end
      OP_B: begin
        decoded[B_UBR] = 1'b1;
      end
      // call writes the return address back to the link register
      OP_CALL: begin
        decoded[B_CALL] = 1'b1;
        decoded[B_UBR]  = 1'b1;
        decoded[B_WB]   = 1'b1;
      end
      OP_RET: begin
        decoded[B_RET] = 1'b1;
        decoded[B_UBR] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_signals <= '0;
    end else begin
      control_signals <= decoded;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [21:0] control_signals;

  int n_checks = 0;
  int n_errors = 0;

  logic [21:0] exp_q[$];

  control_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instruction     (instruction),
    .control_signals (control_signals)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Reference decode written from the opcode tables as set membership.
  function automatic logic [21:0] ref_decode(input logic [31:0] ins);
    logic [4:0]  op;
    logic        ib;
    logic [21:0] v;
    op = ins[31:27];
    ib = ins[26];
    v  = '0;
    v[0]  = (op == 5'd15);
    v[1]  = (op == 5'd14);
    v[2]  = (op == 5'd16);
    v[3]  = (op == 5'd17);
    v[4]  = (op == 5'd20);
    v[5]  = (op < 5'd21) && ib;
    v[6]  = op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8,
                       5'd9, 5'd10, 5'd11, 5'd12, 5'd14, 5'd19};
    v[7]  = op inside {5'd18, 5'd19, 5'd20};
    v[8]  = (op == 5'd19);
    v[9]  = op inside {5'd0, 5'd14, 5'd15};
    v[10] = (op == 5'd1);
    v[11] = (op == 5'd5);
    v[12] = (op == 5'd2);
    v[13] = (op == 5'd3);
    v[14] = (op == 5'd4);
    v[15] = (op == 5'd10);
    v[16] = (op == 5'd11);
    v[17] = (op == 5'd12);
    v[18] = (op == 5'd7);
    v[19] = (op == 5'd6);
    v[20] = (op == 5'd8);
    v[21] = (op == 5'd9);
    return v;
  endfunction

  // Drive one instruction on the falling edge, queue its expected decode,
  // and compare after the next rising edge.
  task automatic drive(input string tag, input logic [31:0] ins, input logic [21:0] exp);
    @(negedge clk);
    instruction = ins;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_val(tag, control_signals, exp_q.pop_front());
  endtask

  typedef struct {
    string       tag;
    logic [31:0] ins;
    logic [21:0] exp;
  } vec_t;

  vec_t dir_vecs[$];

  initial begin
    rst_n       = 1'b0;
    instruction = $urandom;
    #2;
    check_val("reset_async", control_signals, 22'h0);
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_held_over_edges", control_signals, 22'h0);

    // release reset, first edge loads mov immediate
    @(negedge clk);
    rst_n       = 1'b1;
    instruction = 32'h4C000005;
    exp_q.push_back(22'h200060);
    @(posedge clk);
    #1;
    check_val("mov_imm_after_reset", control_signals, exp_q.pop_front());

    // instruction change between edges must not reach the output
    #1;
    instruction = 32'h00000000;
    #1;
    check_val("hold_between_edges", control_signals, 22'h200060);

    // asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    check_val("async_reset_mid_cycle", control_signals, 22'h0);
    @(posedge clk);
    #1;
    check_val("reset_blocks_edge", control_signals, 22'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(22'h000240);
    @(posedge clk);
    #1;
    check_val("first_edge_after_release", control_signals, exp_q.pop_front());

    // directed values from the decode table
    dir_vecs.push_back('{"add_reg",     32'h00000000, 22'h000240});
    dir_vecs.push_back('{"st_imm",      32'h7C000000, 22'h000221});
    dir_vecs.push_back('{"call",        32'h98000000, 22'h0001C0});
    dir_vecs.push_back('{"ret",         32'hA0000000, 22'h000090});
    dir_vecs.push_back('{"cmp_imm",     32'h2C000000, 22'h000820});
    dir_vecs.push_back('{"invalid_31",  32'hFC000000, 22'h000000});
    dir_vecs.push_back('{"nop",         32'h68000000, 22'h000000});
    dir_vecs.push_back('{"nop_imm",     32'h6C000000, 22'h000020});
    dir_vecs.push_back('{"invalid_21",  32'hAC00ABCD, 22'h000000});
    dir_vecs.push_back('{"ld_reg",      32'h70000000, 22'h000242});
    dir_vecs.push_back('{"b_uncond",    32'h93FFFFFF, 22'h000080});
    dir_vecs.push_back('{"mov_imm",     32'h4C000005, 22'h200060});
    foreach (dir_vecs[k]) drive(dir_vecs[k].tag, dir_vecs[k].ins, dir_vecs[k].exp);

    // every opcode with both I values and random low bits, back to back
    for (int op = 0; op < 32; op++) begin
      for (int ib = 0; ib < 2; ib++) begin
        logic [31:0] w;
        w        = $urandom;
        w[31:27] = op[4:0];
        w[26]    = ib[0];
        drive($sformatf("sweep_op%0d_i%0d", op, ib), w, ref_decode(w));
      end
    end

    // random back-to-back instructions
    for (int n = 0; n < 200; n++) begin
      logic [31:0] w;
      w = $urandom;
      drive("random", w, ref_decode(w));
    end

    check_val("scoreboard_drained", 22'(exp_q.size()), 22'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instruction  input  32  instruction word to decode.
REQ-005 control_signals  output  22  registered decoded control vector.
REQ-006 control_signals bit map:
- 0 isSt, 1 isLd, 2 isBeq, 3 isBgt, 4 isRet, 5 isImmediate
- 6 isWb, 7 isUbranch, 8 isCall, 9 isAdd, 10 isSub, 11 isCmp
- 12 isMul, 13 isDiv, 14 isMod, 15 isLsl, 16 isLsr, 17 isAsr
- 18 isOr, 19 isAnd, 20 isNot, 21 isMov

Function
REQ-007 Field extraction: opcode = instruction[31:27] (5 bits); I bit = instruction[26]; bits 25:0 are ignored.
REQ-008 Opcode map, 0-10:
- 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp
- 6 and, 7 or, 8 not, 9 mov, 10 lsl
REQ-009 Opcode map, 11-31:
- 11 lsr, 12 asr, 13 nop, 14 ld, 15 st
- 16 beq, 17 bgt, 18 b, 19 call, 20 ret
- 21-31 invalid
REQ-010 Single-opcode flags: isSub=1, isCmp=5, isMul=2, isDiv=3, isMod=4, isAnd=6, isOr=7, isNot=8, isMov=9, isLsl=10, isLsr=11, isAsr=12, isLd=14, isSt=15, isBeq=16, isBgt=17, isCall=19, isRet=20.
REQ-011 isAdd is set for opcodes 0, 14 and 15 (ld/st address add).
REQ-012 isUbranch is set for opcodes 18, 19 and 20.
REQ-013 isWb is set for opcodes 0-4, 6-12, 14 and 19.
REQ-014 isWb is clear for cmp, nop, st, beq, bgt, b, ret and all invalid opcodes.
REQ-015 isImmediate equals the I bit for opcodes 0-20, and is 0 for opcodes 21-31.
REQ-016 Invalid opcodes (21-31) and nop with I=0 shall produce control_signals = 0.
REQ-017 Decode is combinational into a 22-bit register.
- control_signals updates on every rising clk edge with the decode of instruction sampled at that edge.
- Latency is exactly 1 cycle; there is no enable and no stall.
REQ-018 Between edges, control_signals holds its value regardless of instruction changes; there is no combinational path from instruction to the output.
REQ-019 Decode is a pure function of the sampled opcode and I bit; back-to-back different instructions decode independently each cycle.

Reset
REQ-020 While rst_n = 0, control_signals = 22'h0, asynchronously, independent of clk.
REQ-021 Asserting rst_n mid-operation clears the output immediately, without waiting for a clock edge.
REQ-022 After rst_n rises, the first rising clk edge loads the decode of the current instruction.
REQ-023 If rst_n rises coincident with a clk edge, the output stays 0 until the following edge.

Verification
REQ-024 Reset / mov immediate:
- rst_n = 0 with any instruction -> control_signals = 22'h000000.
- Release rst_n, instruction = 32'h4C000005, one edge -> 22'h200060 (isMov, isWb, isImmediate).
REQ-025 Register and load/store forms:
- instruction = 32'h00000000 (add, register) -> 22'h000240.
- instruction = 32'h7C000000 (st, immediate) -> 22'h000221.
REQ-026 Control-flow forms:
- instruction = 32'h98000000 (call) -> 22'h0001C0.
- instruction = 32'hA0000000 (ret) -> 22'h000090.
- instruction = 32'h2C000000 (cmp, immediate) -> 22'h000820.
REQ-027 Invalid and nop:
- instruction = 32'hFC000000 (opcode 31, I = 1) -> 22'h000000.
- instruction = 32'h68000000 (nop) -> 22'h000000.
REQ-028 Timing:
- Change instruction between edges -> output unchanged until the next rising edge.
- Pull rst_n low mid-cycle while output = 22'h200060 -> output goes to 0 before the next edge.
